im_loader: RTL

Program loader for the instruction memory: accepts a byte stream over a valid/ready handshake, packs bytes little-endian into 32-bit instruction words, and writes them sequentially into the instruction memory's write port starting at address 0. It sits beside the instruction memory, opposite the single-cycle core's fetch path. It holds the core off via `cpu_hold` until the program image is complete.

---
 rtl/im_pkg.sv | 21 ++
 rtl/im_byte_packer.sv | 35 +++
 rtl/im_loader.sv | 136 +++++++++++++
 3 files changed

// File: rtl/im_pkg.sv
// im_pkg: shared widths and FSM state encoding for the instruction-memory loader.
// Revision 1.0
`default_nettype none

package im_pkg;
  localparam int ADDR_BITS      = 5;
  localparam int WORD_WIDTH     = 32;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RECV  = 3'd1,
    S_WRITE = 3'd2,
`ifdef IM_LOADER_CHECKSUM_EN
    S_CHECK = 3'd3,
`endif
    S_DONE  = 3'd4
  } state_t;
endpackage

`default_nettype wire

// File: rtl/im_byte_packer.sv
// im_byte_packer: 2-bit byte counter and little-endian 32-bit word assembly register.
// Revision 1.0
`default_nettype none

module im_byte_packer
  import im_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  accept,
  input  logic [7:0]            data,
  output logic [WORD_WIDTH-1:0] word,
  output logic                  word_ready
);

  logic [1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= 2'd0;
      word <= '0;
    end else if (clear) begin
      cnt <= 2'd0;
    end else if (accept) begin
      word[{cnt, 3'b000} +: 8] <= data;
      cnt                      <= cnt + 2'd1;
    end
  end

  assign word_ready = accept && (cnt == 2'(BYTES_PER_WORD - 1));

endmodule

`default_nettype wire

// File: rtl/im_loader.sv
// im_loader: streams bytes into instruction memory as packed words, holding the core until done.
// Optional trailing checksum byte enabled by IM_LOADER_CHECKSUM_EN. Revision 1.0
`default_nettype none

module im_loader
  import im_pkg::*;
#(
  parameter int ADDR_BITS  = im_pkg::ADDR_BITS,
  parameter int WORD_WIDTH = im_pkg::WORD_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_BITS:0]    len,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  we,
  output logic [ADDR_BITS-1:0]  wa,
  output logic [WORD_WIDTH-1:0] wd,
  output logic                  busy,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  chk_err
);

  localparam logic [ADDR_BITS:0] MAX_LEN = {1'b1, {ADDR_BITS{1'b0}}};
  localparam logic [ADDR_BITS:0] ONE     = {{ADDR_BITS{1'b0}}, 1'b1};

  state_t               state, state_nx;
  logic [ADDR_BITS:0]   len_q;
  logic [ADDR_BITS:0]   idx;
  logic [ADDR_BITS:0]   idx_inc;
  logic [ADDR_BITS:0]   sat_len;
  logic                 start_ok;
  logic                 accept_byte;
  logic                 word_ready;

  assign sat_len     = (len > MAX_LEN) ? MAX_LEN : len;
  assign idx_inc     = idx + ONE;
  assign start_ok    = start && ((state == S_IDLE) || (state == S_DONE));
  assign accept_byte = in_valid && in_ready;

  im_byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (start_ok),
    .accept     (accept_byte && (state == S_RECV)),
    .data       (in_data),
    .word       (wd),
    .word_ready (word_ready)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      len_q <= '0;
      idx   <= '0;
    end else begin
      state <= state_nx;
      if (start_ok) begin
        len_q <= sat_len;
        idx   <= '0;
      end else if (state == S_WRITE) begin
        idx <= idx_inc;
      end
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE, S_DONE: begin
        if (start) state_nx = (sat_len == '0) ? S_DONE : S_RECV;
      end
      S_RECV: begin
        if (word_ready) state_nx = S_WRITE;
      end
      S_WRITE: begin
        if (idx_inc == len_q) begin
`ifdef IM_LOADER_CHECKSUM_EN
          state_nx = S_CHECK;
`else
          state_nx = S_DONE;
`endif
        end else begin
          state_nx = S_RECV;
        end
      end
`ifdef IM_LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (accept_byte) state_nx = S_DONE;
      end
`endif
      default: state_nx = S_IDLE;
    endcase
  end

`ifdef IM_LOADER_CHECKSUM_EN
  logic [7:0] sum;
  logic [7:0] sum_nx;
  logic       chk_q;

  assign sum_nx = sum + in_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum   <= 8'd0;
      chk_q <= 1'b0;
    end else if (start_ok) begin
      sum   <= 8'd0;
      chk_q <= 1'b0;
    end else if (accept_byte) begin
      if (state == S_RECV)  sum   <= sum_nx;
      if (state == S_CHECK) chk_q <= (sum_nx != 8'd0);
    end
  end

  assign chk_err  = chk_q;
  assign in_ready = (state == S_RECV) || (state == S_CHECK);
  assign busy     = (state == S_RECV) || (state == S_WRITE) || (state == S_CHECK);
`else
  assign chk_err  = 1'b0;
  assign in_ready = (state == S_RECV);
  assign busy     = (state == S_RECV) || (state == S_WRITE);
`endif

  // Word index never exceeds 2**ADDR_BITS-1 while in WRITE, so the low bits are the address.
  assign we       = (state == S_WRITE);
  assign wa       = idx[ADDR_BITS-1:0];
  assign cpu_hold = busy;
  assign done     = (state == S_DONE);

endmodule

`default_nettype wire
